// File: rtl/decode_sequencer_if.sv
// Handshake bundle between instruction memory/control and the decode sequencer.
// The master drives fetch data and control; the slave (sequencer) returns IR and strobes.
interface decode_sequencer_if #(
  parameter int unsigned INSTR_W = 16
) ();
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               stall;
  logic               run;

  logic [INSTR_W-1:0] ir;
  logic               fe;
  logic               e1;
  logic               e2;
  logic               pc_cnten;
  logic               instr_rden;
  logic               push_en;
  logic               pop_en;
  logic               stack_full;
  logic               stack_empty;
  logic               halted;
  logic               fault;

  modport master (
    output instr, instr_valid, stall, run,
    input  ir, fe, e1, e2, pc_cnten, instr_rden, push_en, pop_en,
    input  stack_full, stack_empty, halted, fault
  );

  modport slave (
    input  instr, instr_valid, stall, run,
    output ir, fe, e1, e2, pc_cnten, instr_rden, push_en, pop_en,
    output stack_full, stack_empty, halted, fault
  );
endinterface

// File: rtl/decode_sequencer.sv
// Phase sequencer for the multi-cycle CPU: fe/e1/e2 strobes, multiplier wait states,
// stall freeze, halt/restart and a stack-occupancy tracker with sticky fault.
module decode_sequencer #(
  parameter int unsigned INSTR_W     = 16,
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned STACK_DEPTH = 8
) (
  input logic                clk,
  input logic                reset_n,
  decode_sequencer_if.slave  bus
);

  localparam int unsigned OccW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned WaitW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  localparam logic [OccW-1:0]  OccFull  = OccW'(STACK_DEPTH);
  localparam logic [OccW-1:0]  OccOne   = OccW'(1);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(MUL_LAT - 1);
  localparam logic [WaitW-1:0] WaitOne  = WaitW'(1);

  typedef enum logic [2:0] {
    StFetch,
    StE1,
    StWait,
    StE2,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsOne,
    ClsTwo,
    ClsMul,
    ClsStk,
    ClsStp
  } cls_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [OccW-1:0]    occ_q, occ_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               fault_q, fault_d;

  logic [4:0] op;
  logic       is_pop;
  cls_e       cls;

  logic fe, e1, e2, pc_cnten, instr_rden, push_en, pop_en;

  assign op     = ir_q[INSTR_W-1 -: 5];
  assign is_pop = ir_q[INSTR_W-6];

  always_comb begin
    cls = ClsOne;
    if (op == 5'b00000) begin
      cls = ClsStp;
    end else if (op == 5'b01001) begin
      cls = ClsMul;
    end else if (op == 5'b01101) begin
      cls = ClsStk;
    end else if ((op[4:1] == 4'b0001) || (op[4:1] == 4'b0011) ||
                 (op == 5'b01110) || (op[4:2] == 3'b110)) begin
      cls = ClsTwo;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    occ_d      = occ_q;
    wait_d     = wait_q;
    fault_d    = fault_q;
    fe         = 1'b0;
    e1         = 1'b0;
    e2         = 1'b0;
    pc_cnten   = 1'b0;
    instr_rden = 1'b0;
    push_en    = 1'b0;
    pop_en     = 1'b0;

    // Stall freezes everything; only reset overrides it.
    if (!bus.stall) begin
      unique case (state_q)
        StFetch: begin
          fe         = 1'b1;
          instr_rden = 1'b1;
          if (bus.instr_valid) begin
            ir_d     = bus.instr;
            pc_cnten = 1'b1;
            state_d  = StE1;
          end
        end
        StE1: begin
          e1 = 1'b1;
          unique case (cls)
            ClsOne: begin
              pc_cnten   = 1'b1;
              instr_rden = 1'b1;
              state_d    = StFetch;
            end
            ClsStk: begin
              if (!is_pop && (occ_q != OccFull)) begin
                push_en    = 1'b1;
                occ_d      = occ_q + OccOne;
                pc_cnten   = 1'b1;
                instr_rden = 1'b1;
                state_d    = StFetch;
              end else if (is_pop && (occ_q != '0)) begin
                pop_en     = 1'b1;
                occ_d      = occ_q - OccOne;
                pc_cnten   = 1'b1;
                instr_rden = 1'b1;
                state_d    = StFetch;
              end else begin
                fault_d = 1'b1;
                state_d = StHalt;
              end
            end
            ClsTwo: state_d = StE2;
            ClsMul: begin
              if (MUL_LAT > 1) begin
                wait_d  = WaitLoad;
                state_d = StWait;
              end else begin
                state_d = StE2;
              end
            end
            ClsStp: state_d = StHalt;
            default: state_d = StFetch;
          endcase
        end
        StWait: begin
          wait_d = wait_q - WaitOne;
          if (wait_q <= WaitOne) begin
            state_d = StE2;
          end
        end
        StE2: begin
          e2         = 1'b1;
          pc_cnten   = 1'b1;
          instr_rden = 1'b1;
          state_d    = StFetch;
        end
        StHalt: begin
          if (bus.run) begin
            fault_d = 1'b0;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StFetch;
      ir_q    <= '0;
      occ_q   <= '0;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      occ_q   <= occ_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign bus.ir          = ir_q;
  assign bus.fe          = fe;
  assign bus.e1          = e1;
  assign bus.e2          = e2;
  assign bus.pc_cnten    = pc_cnten;
  assign bus.instr_rden  = instr_rden;
  assign bus.push_en     = push_en;
  assign bus.pop_en      = pop_en;
  assign bus.stack_full  = (occ_q == OccFull);
  assign bus.stack_empty = (occ_q == '0);
  assign bus.halted      = (state_q == StHalt);
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_decode_sequencer.sv
// Directed bench for decode_sequencer (MUL_LAT=3, STACK_DEPTH=2); stimulus pushes the
// expected per-cycle output vector, a negedge monitor pops and compares.
module tb_decode_sequencer;

  logic clk;
  logic reset_n;

  decode_sequencer_if #(.INSTR_W(16)) bus ();

  decode_sequencer #(
    .INSTR_W    (16),
    .MUL_LAT    (3),
    .STACK_DEPTH(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector order: fe e1 e2 pc_cnten instr_rden push pop full empty halted fault
  typedef struct {
    logic [10:0] bits;
    logic [15:0] ir;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [10:0] act;
      e   = exp_q.pop_front();
      act = {bus.fe, bus.e1, bus.e2, bus.pc_cnten, bus.instr_rden, bus.push_en,
             bus.pop_en, bus.stack_full, bus.stack_empty, bus.halted, bus.fault};
      checks++;
      if (act !== e.bits || bus.ir !== e.ir) begin
        errors++;
        $display("FAIL %s: got bits=%b ir=%h, want bits=%b ir=%h",
                 e.nm, act, bus.ir, e.bits, e.ir);
      end
    end
  end

  task automatic step(input logic rst, input logic [15:0] instr, input logic valid,
                      input logic stall, input logic run, input logic [10:0] bits,
                      input logic [15:0] ir, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n         = rst;
    bus.instr       = instr;
    bus.instr_valid = valid;
    bus.stall       = stall;
    bus.run         = run;
    e.bits = bits;
    e.ir   = ir;
    e.nm   = nm;
    exp_q.push_back(e);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    reset_n         = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.stall       = 1'b0;
    bus.run         = 1'b0;
    repeat (2) @(posedge clk);

    // ADR after reset: fe, e1, fe with pc_cnten in fe and e1
    step(1, 16'h0800, 1, 0, 0, 11'b10011000100, 16'h0000, "reset_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01011000100, 16'h0800, "adr_e1");
    // instr_valid low three cycles; run ignored outside HALT
    step(1, 16'h0000, 0, 0, 1, 11'b10001000100, 16'h0800, "fetch_wait1");
    step(1, 16'h0000, 0, 0, 0, 11'b10001000100, 16'h0800, "fetch_wait2");
    step(1, 16'h0000, 0, 0, 0, 11'b10001000100, 16'h0800, "fetch_wait3");
    // MLR: fe, e1, WAIT, WAIT, e2
    step(1, 16'h4800, 1, 0, 0, 11'b10011000100, 16'h0800, "mul_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01000000100, 16'h4800, "mul_e1");
    step(1, 16'h0000, 0, 0, 0, 11'b00000000100, 16'h4800, "mul_wait1");
    step(1, 16'h0000, 0, 0, 0, 11'b00000000100, 16'h4800, "mul_wait2");
    step(1, 16'h0000, 0, 0, 0, 11'b00111000100, 16'h4800, "mul_e2");
    // TWO-class with stall in E2
    step(1, 16'h1000, 1, 0, 0, 11'b10011000100, 16'h4800, "two_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01000000100, 16'h1000, "two_e1");
    step(1, 16'h0000, 0, 1, 0, 11'b00000000100, 16'h1000, "two_e2_stall1");
    step(1, 16'h0000, 0, 1, 0, 11'b00000000100, 16'h1000, "two_e2_stall2");
    step(1, 16'h0000, 0, 0, 0, 11'b00111000100, 16'h1000, "two_e2");
    // Stall in FETCH blocks the latch
    step(1, 16'h6800, 1, 1, 0, 11'b00000000100, 16'h1000, "fetch_stall");
    // push, push -> full, third push faults and halts
    step(1, 16'h6800, 1, 0, 0, 11'b10011000100, 16'h1000, "push1_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01011100100, 16'h6800, "push1_e1");
    step(1, 16'h6800, 1, 0, 0, 11'b10011000000, 16'h6800, "push2_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01011100000, 16'h6800, "push2_e1");
    step(1, 16'h6800, 1, 0, 0, 11'b10011001000, 16'h6800, "push3_fe_full");
    step(1, 16'h0000, 0, 0, 0, 11'b01000001000, 16'h6800, "push3_e1_over");
    step(1, 16'h0000, 0, 0, 0, 11'b00000001011, 16'h6800, "over_halt");
    step(1, 16'h0000, 0, 0, 1, 11'b00000001011, 16'h6800, "over_run");
    // Pop twice back to empty
    step(1, 16'h6C00, 1, 0, 0, 11'b10011001000, 16'h6800, "pop1_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01011011000, 16'h6C00, "pop1_e1");
    step(1, 16'h6C00, 1, 0, 0, 11'b10011000000, 16'h6C00, "pop2_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01011010000, 16'h6C00, "pop2_e1");
    // Reset, then pop from empty
    step(0, 16'h0000, 0, 0, 0, 11'b10001000100, 16'h6C00, "pre_reset");
    step(1, 16'h6C00, 1, 0, 0, 11'b10011000100, 16'h0000, "under_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01000000100, 16'h6C00, "under_e1");
    step(1, 16'h0000, 0, 0, 0, 11'b00000000111, 16'h6C00, "under_halt");
    step(1, 16'h0000, 0, 0, 1, 11'b00000000111, 16'h6C00, "under_run");
    // STP: halts without fault and without pc_cnten in e1
    step(1, 16'h0000, 1, 0, 0, 11'b10011000100, 16'h6C00, "stp_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01000000100, 16'h0000, "stp_e1");
    step(1, 16'h0000, 0, 0, 0, 11'b00000000110, 16'h0000, "stp_halt");
    step(1, 16'h0000, 0, 1, 1, 11'b00000000110, 16'h0000, "stp_halt_stall");
    step(1, 16'h0000, 0, 0, 1, 11'b00000000110, 16'h0000, "stp_run");
    // Reset during stalled WAIT aborts the multiply
    step(1, 16'h4800, 1, 0, 0, 11'b10011000100, 16'h0000, "abort_fe");
    step(1, 16'h0000, 0, 0, 0, 11'b01000000100, 16'h4800, "abort_e1");
    step(1, 16'h0000, 0, 1, 0, 11'b00000000100, 16'h4800, "abort_wait_stall");
    step(0, 16'h0000, 0, 1, 0, 11'b00000000100, 16'h4800, "abort_reset");
    step(1, 16'h0000, 0, 0, 0, 11'b10001000100, 16'h0000, "abort_after");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
